// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers HH:MM digits from a scanned active-low seven-segment pin stream
//
// Ports:
//   clk          system clock, single domain
//   reset        asynchronous active-low reset
//   an[3:0]      digit enables, active-low; an[0] = minute ones .. an[3] = hour tens
//   seg[6:0]     segments, active-low; seg[0] = a .. seg[6] = g
//   digit0..3    published digits (0-9, 4'hF for an unrecognised pattern)
//   digits_ok    all four published digits are 0-9
//   frame_valid  one-cycle pulse when a new frame is published
//   err_an       one-cycle pulse when an settles with more than one bit low
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       digits_ok,
  output logic       frame_valid,
  output logic       err_an
);

  localparam int              CW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   SETTLE_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      STABLE_MAX  = 4'(STABLE_FRAMES);

  // Input synchronizers; blank (all ones) out of reset.
  logic [3:0] an_meta;
  logic [3:0] an_sync;
  logic [6:0] seg_meta;
  logic [6:0] seg_sync;

  // Dwell tracking.
  logic [3:0]    an_prev;
  logic [CW-1:0] settle_cnt;

  // Frame assembly: four nibbles packed slot0 in [3:0] .. slot3 in [15:12].
  logic [15:0] slots_q;
  logic [3:0]  seen_q;
  logic [15:0] prev_frame;
  logic [3:0]  match_cnt;

  // Combinational helpers.
  logic        an_changed;
  logic        sample;
  logic        one_hot;
  logic        blank;
  logic [1:0]  slot_idx;
  logic [3:0]  cur_digit;
  logic [15:0] frame_next;
  logic [3:0]  seen_next;
  logic        capture;
  logic        complete;
  logic        same_frame;
  logic [3:0]  match_next;
  logic        publish;
  logic        frame_ok;

  // Active-low g..a pattern to digit; unknown patterns map to 4'hF.
  function automatic logic [3:0] decode_seg(input logic [6:0] s);
    logic [3:0] d;
    case (s)
      7'b1000000: d = 4'd0;
      7'b1111001: d = 4'd1;
      7'b0100100: d = 4'd2;
      7'b0110000: d = 4'd3;
      7'b0011001: d = 4'd4;
      7'b0010010: d = 4'd5;
      7'b0000010: d = 4'd6;
      7'b1111000: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0010000: d = 4'd9;
      default:    d = 4'hF;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_meta  <= 4'hF;
      an_sync  <= 4'hF;
      seg_meta <= 7'h7F;
      seg_sync <= 7'h7F;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      seg_meta <= seg;
      seg_sync <= seg_meta;
    end
  end

  // The sample fires on the edge where the counter would step onto
  // SETTLE_CYCLES; once saturated it never fires again in the same dwell.
  always_comb begin
    an_changed = (an_sync != an_prev);
    sample     = !an_changed && (settle_cnt == SETTLE_LAST);
  end

  always_comb begin
    one_hot  = 1'b0;
    blank    = 1'b0;
    slot_idx = 2'd0;
    case (an_sync)
      4'b1110: begin one_hot = 1'b1; slot_idx = 2'd0; end
      4'b1101: begin one_hot = 1'b1; slot_idx = 2'd1; end
      4'b1011: begin one_hot = 1'b1; slot_idx = 2'd2; end
      4'b0111: begin one_hot = 1'b1; slot_idx = 2'd3; end
      4'b1111: blank = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cur_digit  = decode_seg(seg_sync);
    frame_next = slots_q;
    seen_next  = seen_q;
    if (one_hot) begin
      frame_next[4*slot_idx +: 4] = cur_digit;
      seen_next[slot_idx]         = 1'b1;
    end
    capture    = sample && one_hot;
    complete   = capture && (seen_next == 4'hF);
    same_frame = (frame_next == prev_frame);
    if (!same_frame) begin
      match_next = 4'd1;
    end else if (match_cnt == STABLE_MAX) begin
      match_next = match_cnt;
    end else begin
      match_next = match_cnt + 4'd1;
    end
    // A frame already published and repeated keeps match_cnt saturated,
    // which is what suppresses re-publishing it.
    publish  = complete && (match_next == STABLE_MAX) &&
               !(same_frame && (match_cnt == STABLE_MAX));
    frame_ok = (frame_next[3:0]   < 4'd10) && (frame_next[7:4]   < 4'd10) &&
               (frame_next[11:8]  < 4'd10) && (frame_next[15:12] < 4'd10);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_prev    <= 4'hF;
      settle_cnt <= '0;
    end else begin
      an_prev <= an_sync;
      if (an_changed) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slots_q    <= 16'hFFFF;
      seen_q     <= 4'h0;
      prev_frame <= 16'hFFFF;
      match_cnt  <= 4'd0;
    end else if (capture) begin
      slots_q <= frame_next;
      if (complete) begin
        seen_q     <= 4'h0;
        prev_frame <= frame_next;
        match_cnt  <= match_next;
      end else begin
        seen_q <= seen_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit0      <= 4'd0;
      digit1      <= 4'd0;
      digit2      <= 4'd0;
      digit3      <= 4'd0;
      digits_ok   <= 1'b0;
      frame_valid <= 1'b0;
      err_an      <= 1'b0;
    end else begin
      frame_valid <= publish;
      err_an      <= sample && !one_hot && !blank;
      if (publish) begin
        digit0    <= frame_next[3:0];
        digit1    <= frame_next[7:4];
        digit2    <= frame_next[11:8];
        digit3    <= frame_next[15:12];
        digits_ok <= frame_ok;
      end
    end
  end

endmodule
